// File: rtl/array_acc_pkg.sv
// Shared types and default widths for the array accumulator scheduler.
package array_acc_pkg;
   typedef enum logic {FILL, REPORT} state_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_DW    = 8;
   localparam int DEF_DEPTH = 8;
   localparam int IDX_W     = $clog2(DEF_DEPTH);
   localparam int SRC_W     = $clog2(DEF_NREQ);
   localparam int CNT_W     = IDX_W + 1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int SW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [SW-1:0]   ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [SW-1:0]   idx_o
);
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (en_i && !found && req_i[(int'(ptr_i) + k) % NREQ]) begin
            found = 1'b1;
            gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
            idx_o = SW'((int'(ptr_i) + k) % NREQ);
         end
      end
   end
endmodule

// File: rtl/array_acc_sched.sv
// Round-robin sample scheduler feeding a frame array and running sum;
// each full frame is offered downstream as one sum on a valid/ready port.
module array_acc_sched
   import array_acc_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int DW    = DEF_DW,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int IW    = $clog2(DEPTH),
   localparam int SW    = $clog2(NREQ),
   localparam int CW    = IW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               flush,
   output logic               sum_valid,
   input  logic               sum_ready,
   output logic [DW-1:0]      sum_out,
   output logic [SW-1:0]      sum_src_last,
   output logic [CW-1:0]      fill_level
);
   state_e          state_q;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   wr_q;
   logic [DW-1:0]   sum_q, sum_d;
   logic [SW-1:0]   src_q;
   logic            vld_q;
   logic [DW-1:0]   frame_q [DEPTH];
   logic [NREQ-1:0] gnt;
   logic [SW-1:0]   gidx;
   logic [DW-1:0]   smp;
   logic            xfer;
   logic [DW-1:0]   frame_sum;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .en_i  (state_q == FILL && !flush),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   assign xfer  = |gnt;
   assign smp   = req_data[int'(gidx)*DW +: DW];
   assign sum_d = sum_q + smp;
   assign ptr_d = SW'((int'(gidx) + 1) % NREQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         sum_q   <= '0;
         src_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (flush) begin
                  cnt_q <= '0;
                  wr_q  <= '0;
                  sum_q <= '0;
               end else if (xfer) begin
                  wr_q  <= wr_q + 1'b1;
                  sum_q <= sum_d;
                  cnt_q <= cnt_q + 1'b1;
                  ptr_q <= ptr_d;
                  if (cnt_q == CW'(DEPTH - 1)) begin
                     state_q <= REPORT;
                     src_q   <= gidx;
                     vld_q   <= 1'b1;
                  end
               end
            end
            REPORT: begin
               if (flush || sum_ready) begin
                  cnt_q   <= '0;
                  wr_q    <= '0;
                  sum_q   <= '0;
                  vld_q   <= 1'b0;
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   // Frame storage carries no reset; its contents are only meaningful per frame.
   always_ff @(posedge clk) begin
      if (state_q == FILL && !flush && xfer) frame_q[wr_q] <= smp;
   end

   always_comb begin
      frame_sum = '0;
      for (int i = 0; i < DEPTH; i++) frame_sum = frame_sum + frame_q[i];
   end

   assign req_ready    = gnt;
   assign sum_valid    = vld_q;
   assign sum_out      = sum_q;
   assign sum_src_last = src_q;
   assign fill_level   = cnt_q;

   a_onehot_gnt: assert property (
      @(posedge clk) disable iff (rst) $onehot0(req_ready));

   a_frame_sum: assert property (
      @(posedge clk) disable iff (rst)
      (state_q == REPORT) |-> (frame_sum == sum_q));
endmodule

// File: tb/tb_array_acc_sched.sv
// Randomized and directed check of array_acc_sched against a queue-based model.
module tb_array_acc_sched;
   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               flush;
   logic               sum_valid;
   logic               sum_ready;
   logic [DW-1:0]      sum_out;
   logic [1:0]         sum_src_last;
   logic [3:0]         fill_level;

   int n_vec = 0;
   int n_err = 0;

   bit m_rep;
   int m_ptr;
   int m_src;
   int q[$];

   array_acc_sched #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .flush        (flush),
      .sum_valid    (sum_valid),
      .sum_ready    (sum_ready),
      .sum_out      (sum_out),
      .sum_src_last (sum_src_last),
      .fill_level   (fill_level)
   );

   always #5 clk = ~clk;

   function automatic int m_grant();
      if (m_rep || flush) return -1;
      for (int k = 0; k < NREQ; k++)
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic int m_sum();
      int s = 0;
      foreach (q[i]) s += q[i];
      return s % 256;
   endfunction

   task automatic model_reset();
      m_rep = 0;
      m_ptr = 0;
      m_src = 0;
      q.delete();
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      int g;
      g = m_grant();
      chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
      chk("sum_valid", int'(sum_valid), int'(m_rep));
      chk("sum_out", int'(sum_out), m_sum());
      chk("sum_src_last", int'(sum_src_last), m_src);
      chk("fill_level", int'(fill_level), q.size());
   endtask

   task automatic model_update();
      int g;
      g = m_grant();
      if (m_rep) begin
         if (flush || sum_ready) begin
            m_rep = 0;
            q.delete();
         end
      end else if (flush) begin
         q.delete();
      end else if (g >= 0) begin
         q.push_back(int'(req_data[g*DW +: DW]));
         m_ptr = (g + 1) % NREQ;
         if (q.size() == DEPTH) begin
            m_rep = 1;
            m_src = g;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      flush     = 1'b0;
      sum_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sum_valid", int'(sum_valid), 0);
      chk("rst_fill", int'(fill_level), 0);
      chk("rst_sum", int'(sum_out), 0);
      chk("rst_src", int'(sum_src_last), 0);
      rst = 1'b0;

      for (int k = 1; k <= 8; k++) begin
         req_valid = 4'b0001;
         req_data  = 32'(k);
         step();
      end
      req_valid = '0;
      chk("t1_valid", int'(sum_valid), 1);
      chk("t1_sum", int'(sum_out), 36);
      chk("t1_src", int'(sum_src_last), 0);
      chk("t1_fill", int'(fill_level), 8);
      sum_ready = 1'b1;
      step();
      chk("t1_fill_after", int'(fill_level), 0);
      sum_ready = 1'b0;

      for (int k = 0; k < 8; k++) begin
         req_valid = 4'b0001;
         req_data  = 32'h0000_00FF;
         step();
      end
      chk("wrap_sum", int'(sum_out), 'hF8);
      req_valid = '0;
      sum_ready = 1'b1;
      step();
      sum_ready = 1'b0;

      req_valid = '1;
      for (int k = 0; k < 3; k++) begin
         req_data = $urandom;
         step();
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_fill", int'(fill_level), 0);
      chk("arst_sum", int'(sum_out), 0);
      chk("arst_valid", int'(sum_valid), 0);
      chk("arst_gnt", int'(req_ready), 1);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_regnt", int'(req_ready), 1);

      sum_ready = 1'b1;
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         req_data = $urandom;
         step();
      end
      chk("rr_src", int'(sum_src_last), 3);
      chk("rr_valid", int'(sum_valid), 1);
      for (int k = 0; k < 8; k++) begin
         req_data = $urandom;
         step();
      end

      sum_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         req_data = $urandom;
         step();
      end
      chk("hold_valid", int'(sum_valid), 1);
      chk("hold_gnt", int'(req_ready), 0);
      sum_ready = 1'b1;
      step();
      sum_ready = 1'b0;

      req_valid = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         req_data = 32'(k * 10);
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_fill", int'(fill_level), 0);
      for (int k = 0; k < 8; k++) begin
         req_data = 32'h0000_0001;
         step();
      end
      req_valid = '0;
      chk("flush_sum", int'(sum_out), 8);
      chk("flush_rep", int'(sum_valid), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("rflush_valid", int'(sum_valid), 0);
      chk("rflush_fill", int'(fill_level), 0);

      for (int k = 0; k < 3000; k++) begin
         req_valid = NREQ'($urandom);
         req_data  = $urandom;
         flush     = ($urandom_range(0, 29) == 0);
         sum_ready = 1'($urandom_range(0, 1));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
